// File: rtl/riscv_structures.sv
// Shared types for the 5-stage RISC-V pipeline.
//   ex_to_mem_s : execute -> memory stage register
//   mem_to_wb_s : memory -> writeback stage register
//   mem_state_e : memory stage access sequencer states
//   DMEM_TIMEOUT_DEFAULT : default data-memory access timeout in cycles
package riscv_structures;

  localparam int DMEM_TIMEOUT_DEFAULT = 16;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic        mem_write;
    logic        reg_write;
    logic [4:0]  rd;
    logic        mem_read;
  } ex_to_mem_s;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_write;
  } mem_to_wb_s;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Counts cycles spent waiting for a data-memory acknowledge.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : return the count to zero (takes priority over en)
//   en        : advance the count by one
//   expired   : count has reached TIMEOUT_CYCLES-1
module dmem_timeout_ctr
  import riscv_structures::*;
#(
  parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // The count parks at LAST; the owner leaves its wait state on expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage RISC-V pipeline.
// Issues one word load/store at a time over a req/ack handshake, stalls the
// upstream stages while the access is outstanding, and registers the
// writeback bundle.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   ex_to_mem         : instruction from execute (held stable while stalled)
//   dmem_req/we/addr/wdata : registered data-memory request
//   dmem_ack, dmem_rdata   : memory response (only meaningful while dmem_req)
//   stall_mem         : freezes PC/IF/ID/EX registers
//   bp_mem            : MEM-stage bypass value to execute
//   mem_rd, mem_reg_write : destination info for the hazard unit
//   mem_to_wb         : registered bundle for writeback
//   mem_err           : sticky access-timeout flag
module mem_stage
  import riscv_structures::*;
#(
  parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  ex_to_mem_s  ex_to_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic [31:0] bp_mem,
  output logic [4:0]  mem_rd,
  output logic        mem_reg_write,
  output mem_to_wb_s  mem_to_wb,
  output logic        mem_err
);

  mem_state_e  state, state_nxt;
  logic        access;
  logic        abort;
  logic [31:0] load_buf;
  logic        expired;

  assign access        = ex_to_mem.mem_read | ex_to_mem.mem_write;
  assign bp_mem        = ex_to_mem.alu_result;
  assign mem_rd        = ex_to_mem.rd;
  assign mem_reg_write = ex_to_mem.reg_write;

  // Wait counter runs only while a request is outstanding and unacknowledged.
  dmem_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != REQ),
    .en      ((state == REQ) && !dmem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DONE releases the stall so upstream advances in the same cycle that the
  // completed access is written to mem_to_wb.
  always_comb begin
    state_nxt = state;
    stall_mem = 1'b0;
    case (state)
      IDLE: begin
        stall_mem = access;
        if (access) state_nxt = REQ;
      end
      REQ: begin
        stall_mem = 1'b1;
        if (dmem_ack || expired) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      load_buf   <= '0;
      abort      <= 1'b0;
      mem_err    <= 1'b0;
      mem_to_wb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            dmem_req   <= 1'b1;
            dmem_we    <= ex_to_mem.mem_write;
            dmem_addr  <= ex_to_mem.alu_result;
            dmem_wdata <= ex_to_mem.write_data;
          end
        end
        REQ: begin
          // An ack on the final allowed cycle wins over the timeout.
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) load_buf <= dmem_rdata;
          end else if (expired) begin
            dmem_req <= 1'b0;
            mem_err  <= 1'b1;
            abort    <= 1'b1;
          end
        end
        DONE: begin
          abort <= 1'b0;
        end
        default: begin
        end
      endcase

      // While stalled only the valid bit matters: insert a bubble.
      if (stall_mem) begin
        mem_to_wb.reg_write <= 1'b0;
      end else begin
        mem_to_wb.result    <= ex_to_mem.mem_read ? load_buf : ex_to_mem.alu_result;
        mem_to_wb.rd        <= ex_to_mem.rd;
        mem_to_wb.reg_write <= ex_to_mem.reg_write & ~abort;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage RISC-V pipeline. It is the consumer of the ex_to_mem_s register that the execute stage produces.
- Issues word-wide loads and stores to the data memory over a req/ack handshake. Stalls the upstream stages while an access is outstanding.
- Supplies the MEM bypass value (bp_mem) to execute. Registers the mem_to_wb_s bundle for writeback.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in REQ without dmem_ack before the access is aborted. Must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_to_mem  in  ex_to_mem_s  fields: alu_result, write_data, mem_write, reg_write, rd, mem_read. Upstream holds it stable while stall_mem=1.
- dmem_req  out  1  access request, registered.
- dmem_we  out  1  1=store, 0=load. Registered.
- dmem_addr  out  32  word address (alu_result). Registered.
- dmem_wdata  out  32  store data (write_data). Registered.
- dmem_ack  in  1  access complete. Valid only while dmem_req=1.
- dmem_rdata  in  32  load data. Valid with dmem_ack on loads.
- stall_mem  out  1  combinational. Freezes PC, fetch, decode and execute registers.
- bp_mem  out  32  combinational. Equals ex_to_mem.alu_result.
- mem_rd  out  5  ex_to_mem.rd, for the hazard unit.
- mem_reg_write  out  1  ex_to_mem.reg_write, for the hazard unit.
- mem_to_wb  out  mem_to_wb_s  registered bundle: result[31:0], rd[4:0], reg_write.
- mem_err  out  1  sticky access-timeout flag.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - mem_to_wb all fields 0. mem_err=0. Timeout counter=0. load_buf=0.
- access = ex_to_mem.mem_read | ex_to_mem.mem_write.
- Reads are side-effect-free. A load with reg_write=0 (squashed) still issues; its data is discarded.
- FSM states:
  - IDLE:
    - stall_mem = access.
    - If access: next state REQ. Register dmem_req=1, dmem_we=mem_write, dmem_addr=alu_result, dmem_wdata=write_data. Counter=0.
  - REQ:
    - stall_mem=1. dmem_req, dmem_we, dmem_addr and dmem_wdata held stable.
    - Sample dmem_ack at each edge. On ack: load_buf<=dmem_rdata (loads only), dmem_req<=0, next state DONE.
    - Otherwise counter++. When counter reaches TIMEOUT_CYCLES-1 with no ack: dmem_req<=0, mem_err<=1, abort flag set, next state DONE.
  - DONE:
    - stall_mem=0. Next state IDLE.
    - Upstream advances at this edge; the following instruction is evaluated in IDLE next cycle.
- dmem_ack is ignored outside REQ.
- mem_to_wb update at each edge:
  - If stall_mem=1: mem_to_wb.reg_write<=0 (bubble). result and rd are don't-care.
  - Else: result<=(mem_read ? load_buf : alu_result), rd<=ex_to_mem.rd, reg_write<=ex_to_mem.reg_write & ~abort.
- Abort flag clears on leaving DONE.
- Latency:
  - Non-memory instruction: 0 stall cycles. Result visible in mem_to_wb 1 edge after presentation.
  - Load/store with ack in first REQ cycle: 2 stall cycles. mem_to_wb written at the 3rd edge.
  - Each wait cycle adds 1 stall cycle.
- bp_mem always reflects alu_result. Load-use forwarding is not provided; the hazard unit stalls load-use dependencies.
- Back-to-back accesses are handled as IDLE→REQ→DONE→IDLE→REQ. There is no pipelined issue.
- rst asserted mid-REQ: dmem_req drops asynchronously. The outstanding access is abandoned, and a late dmem_ack after reset is ignored.
- mem_err stays 1 until rst.

Decomposition:
- riscv_structures.sv gains:
  - mem_to_wb_s {result, rd, reg_write}.
  - mem_state_e {IDLE, REQ, DONE}.
  - localparam DMEM_TIMEOUT_DEFAULT=16.
- One sub-module: dmem_timeout_ctr. Clear/enable inputs, expired output, parameterised by TIMEOUT_CYCLES, async reset.
- FSM, load_buf and the mem_to_wb register stay in mem_stage.

Test Plan:
- ALU op: alu_result=0x10, rd=5, reg_write=1, no mem. Response: stall_mem=0; next edge mem_to_wb={0x10,5,1}; dmem_req never 1.
- Load at 0x100, ack in first REQ cycle with rdata=0xCAFEBABE, rd=7. Response: dmem_req=1 for exactly 1 cycle with dmem_we=0 and addr=0x100; stall_mem=1 for 2 cycles; mem_to_wb={0xCAFEBABE,7,1} after the 3rd edge.
- Store of wdata=0x12345678 to 0x200, ack after 3 wait cycles. Response: dmem_we=1, and addr/wdata stable across all 4 REQ cycles; stall_mem=1 for 5 cycles; mem_to_wb.reg_write=0.
- TIMEOUT_CYCLES=8, load never acked. Response: dmem_req drops after 8 REQ cycles; mem_err=1 and stays 1; mem_to_wb.reg_write=0; the next instruction proceeds normally.
- rst pulsed mid-REQ. Response: dmem_req=0 and mem_to_wb=0 without waiting for a clock edge; state=IDLE; a dmem_ack one cycle later has no effect.
- dmem_ack=1 while IDLE with a non-memory instruction. Response: ignored; load_buf and mem_to_wb.result=alu_result unaffected.
